// File: rtl/booth_mult_seq_pkg.sv
// ============================================================================
// Module  : mult_pkg
// Purpose : Shared types and sizing helpers for the sequential Booth multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mult_op_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Radix-4 digits needed to cover an (XLEN+1)-bit extended multiplier.
  function automatic int calc_ndig(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic int calc_iter(input int xlen, input int dpc);
    return (calc_ndig(xlen) + dpc - 1) / dpc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_seq_digit_gen.sv
// ============================================================================
// Module  : booth_digit_gen
// Purpose : Recodes one 3-bit Booth window into a signed partial product.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_digit_gen
  import mult_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      win_i,
  input  logic [XLEN:0]   a_i,
  output logic [XLEN+1:0] pp_o
);

  booth_sel_e       sel;
  logic [XLEN+1:0]  a1;
  logic [XLEN+1:0]  a2;

  assign a1 = {a_i[XLEN], a_i};
  assign a2 = {a_i, 1'b0};

  always_comb begin
    sel = ZERO;
    case (win_i)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    pp_o = '0;
    case (sel)
      POS1:    pp_o = a1;
      POS2:    pp_o = a2;
      NEG1:    pp_o = -a1;
      NEG2:    pp_o = -a2;
      default: pp_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/booth_mult_seq.sv
// ============================================================================
// Module  : booth_mult_seq
// Purpose : Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU.
//           Optional macro MULT_EARLY_EXIT_EN ends CALC once all remaining
//           Booth digits are zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] oper_a,
  input  logic [XLEN-1:0] oper_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int NDIG = calc_ndig(XLEN);
  localparam int ITER = calc_iter(XLEN, DIGITS_PER_CYCLE);
  localparam int MW   = XLEN + 3;
  localparam int PPW  = XLEN + 2;
  localparam int ACCW = 2 * XLEN + 2;
  localparam int CW   = $clog2(2 * NDIG + 1);

  state_e            state_q;
  mult_op_e          op_q;
  logic [XLEN:0]     a_q;
  logic [MW-1:0]     mreg_q, mreg_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              out_valid_q, in_ready_q, busy_q;

  logic [2:0]        win [DIGITS_PER_CYCLE];
  logic [PPW-1:0]    pp  [DIGITS_PER_CYCLE];
  logic [XLEN:0]     a_ext, b_ext;
  logic [CW-1:0]     base, idx;
  logic              calc_last;

  generate
    for (genvar k = 0; k < DIGITS_PER_CYCLE; k++) begin : g_digit
      assign win[k] = mreg_q[2*k+2 -: 3];
      booth_digit_gen #(.XLEN(XLEN)) u_digit (
        .win_i (win[k]),
        .a_i   (a_q),
        .pp_o  (pp[k])
      );
    end
  endgenerate

  assign a_ext = (mult_op_e'(op) == MULHU) ? {1'b0, oper_a} : {oper_a[XLEN-1], oper_a};
  assign b_ext = (mult_op_e'(op) == MULHSU || mult_op_e'(op) == MULHU)
               ? {1'b0, oper_b} : {oper_b[XLEN-1], oper_b};

  // Digits past NDIG in a short final cycle are masked off.
  always_comb begin
    acc_d = acc_q;
    idx   = '0;
    base  = cnt_q * CW'(DIGITS_PER_CYCLE);
    for (int k = 0; k < DIGITS_PER_CYCLE; k++) begin
      idx = base + CW'(k);
      if (idx < CW'(NDIG))
        acc_d = acc_d + ({{(ACCW-PPW){pp[k][PPW-1]}}, pp[k]} << {idx, 1'b0});
    end
  end

  always_comb begin
    mreg_d    = MW'($signed(mreg_q) >>> (2 * DIGITS_PER_CYCLE));
    calc_last = (cnt_q == CW'(ITER - 1));
`ifdef MULT_EARLY_EXIT_EN
    if ((&mreg_d) || !(|mreg_d))
      calc_last = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= MUL;
      a_q         <= '0;
      mreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q       <= mult_op_e'(op);
            a_q        <= a_ext;
            mreg_q     <= {b_ext[XLEN], b_ext, 1'b0};
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mreg_q <= mreg_d;
          cnt_q  <= cnt_q + CW'(1);
          if (calc_last)
            state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; it is then held until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            result_q    <= (op_q == MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
